// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write-byte reception and read-byte service over an open-drain SDA.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
    input  logic       CLOCK,
    input  logic       Reset,
    input  logic       SCL,
    input  logic       SDAIn,
    output logic       SDADriveLow,
    input  logic [7:0] TxData,
    output logic       TxRequest,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
    } state_t;

    logic   r_scl_s1, r_scl_s2, r_scl_h, r_sda_s1, r_sda_s2, r_sda_h;
    state_t r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_done, w_done_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_drive, w_drive_nxt;
    logic       r_busy, w_busy_nxt;
    logic [7:0] r_rxdata, w_rxdata_nxt;
    logic       r_rxvalid, w_rxvalid_nxt;
    logic       r_txreq, w_txreq_nxt;
    logic [7:0] r_txbyte, w_txbyte_nxt;
    logic       w_load_tx;

    wire w_scl_rise = r_scl_s2 & ~r_scl_h;
    wire w_scl_fall = ~r_scl_s2 & r_scl_h;
    wire w_start    = r_scl_s2 & r_sda_h & ~r_sda_s2;
    wire w_stop     = r_scl_s2 & ~r_sda_h & r_sda_s2;

    // Sync flops idle high so a reset release never looks like a bus edge.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
        end else begin
            r_scl_s1 <= SCL;   r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
            r_sda_s1 <= SDAIn; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
        end
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_done    <= 1'b0;
            r_shift   <= 8'h00;
            r_drive   <= 1'b0;
            r_busy    <= 1'b0;
            r_rxdata  <= 8'h00;
            r_rxvalid <= 1'b0;
            r_txreq   <= 1'b0;
            r_txbyte  <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_shift   <= w_shift_nxt;
            r_drive   <= w_drive_nxt;
            r_busy    <= w_busy_nxt;
            r_rxdata  <= w_rxdata_nxt;
            r_rxvalid <= w_rxvalid_nxt;
            r_txreq   <= w_txreq_nxt;
            r_txbyte  <= w_txbyte_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = r_done;
        w_shift_nxt   = r_shift;
        w_drive_nxt   = r_drive;
        w_busy_nxt    = r_busy;
        w_rxdata_nxt  = r_rxdata;
        w_rxvalid_nxt = 1'b0;
        w_txreq_nxt   = 1'b0;
        w_txbyte_nxt  = r_txbyte;
        w_load_tx     = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_drive_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = 3'd0;
            w_done_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_drive_nxt = 1'b0;
            w_cnt_nxt   = 3'd0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_WRITE: begin
                    if (w_scl_rise && !r_done) begin
                        w_shift_nxt = {r_shift[6:0], r_sda_s2};
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_done_nxt = 1'b1;
                            if (r_state == S_WRITE) begin
                                w_rxdata_nxt  = {r_shift[6:0], r_sda_s2};
                                w_rxvalid_nxt = 1'b1;
                            end
                        end
                    end else if (w_scl_fall && r_done) begin
                        w_done_nxt = 1'b0;
                        if (r_state == S_WRITE) begin
                            w_drive_nxt = 1'b1;
                            w_state_nxt = S_WRITE_ACK;
                        end else if (r_shift[7:1] == SLAVE_ADDR) begin
                            w_drive_nxt = 1'b1;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_ADDR_ACK;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_shift[0]) begin
                            w_drive_nxt = 1'b0;
                            w_cnt_nxt   = 3'd0;
                            w_state_nxt = S_WRITE;
                        end else begin
                            w_load_tx = 1'b1;
                        end
                    end
                end
                S_WRITE_ACK: begin
                    if (w_scl_fall) begin
                        w_drive_nxt = 1'b0;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_WRITE;
                    end
                end
                // r_cnt indexes the next bit to drive; done marks bit 0 on the wire.
                S_READ: begin
                    if (w_scl_fall) begin
                        if (r_done) begin
                            w_drive_nxt = 1'b0;
                            w_done_nxt  = 1'b0;
                            w_cnt_nxt   = 3'd0;
                            w_state_nxt = S_READ_ACK;
                        end else begin
                            w_drive_nxt = ~r_txbyte[r_cnt];
                            if (r_cnt == 3'd0) w_done_nxt = 1'b1;
                            else               w_cnt_nxt  = r_cnt - 3'd1;
                        end
                    end
                end
                S_READ_ACK: begin
                    if (w_scl_rise && !r_done) begin
                        if (r_sda_s2) begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_WAIT_STOP;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_done) begin
                        w_done_nxt = 1'b0;
                        w_load_tx  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (w_load_tx) begin
            w_txbyte_nxt = TxData;
            w_txreq_nxt  = 1'b1;
            w_drive_nxt  = ~TxData[7];
            w_cnt_nxt    = 3'd6;
            w_state_nxt  = S_READ;
        end
    end

    assign SDADriveLow = r_drive;
    assign TxRequest   = r_txreq;
    assign RxData      = r_rxdata;
    assign RxValid     = r_rxvalid;
    assign Busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bus-level bench: a behavioural I2C master drives the responder; expectations
// come from transaction-level rules (address match, bytes written/read).
module tb_i2c_slave_responder;

    localparam logic [6:0] ADDR = 7'h48;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       drv, txreq, rxvalid, busy;
    logic [7:0] rxdata;
    logic       sda_w;

    int n_cmp = 0;
    int n_bad = 0;
    int rxv_cnt = 0, txr_cnt = 0, drv_cnt = 0, viol_cnt = 0, scl_hi = 0;

    assign sda_w = m_sda & ~drv;

    i2c_slave_responder #(.SLAVE_ADDR(ADDR)) dut (
        .CLOCK(clk), .Reset(rst_n), .SCL(scl), .SDAIn(sda_w),
        .SDADriveLow(drv), .TxData(tx_data), .TxRequest(txreq),
        .RxData(rxdata), .RxValid(rxvalid), .Busy(busy)
    );

    always #5 clk = ~clk;

    // Bus monitors: pulse counts and "no new drive while SCL is high".
    always @(posedge clk) begin
        scl_hi <= scl ? scl_hi + 1 : 0;
        if (rst_n) begin
            if (rxvalid) rxv_cnt <= rxv_cnt + 1;
            if (txreq)   txr_cnt <= txr_cnt + 1;
            if (drv)     drv_cnt <= drv_cnt + 1;
            if (scl_hi >= 3 && drv && !dut.r_drive) viol_cnt <= viol_cnt;
        end
    end

    logic drv_q = 1'b0;
    always @(posedge clk) begin
        drv_q <= drv;
        if (rst_n && scl && scl_hi >= 3 && drv && !drv_q) viol_cnt <= viol_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        tick(4); m_sda = b;
        tick(4); scl = 1'b1;
        tick(4); s = sda_w;
        tick(4); scl = 1'b0;
    endtask

    task automatic bus_start();
        tick(4); m_sda = 1'b0;
        tick(6); scl = 1'b0;
    endtask

    task automatic bus_rstart();
        tick(4); m_sda = 1'b1;
        tick(4); scl = 1'b1;
        tick(6); m_sda = 1'b0;
        tick(6); scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(4); m_sda = 1'b0;
        tick(4); scl = 1'b1;
        tick(6); m_sda = 1'b1;
        tick(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] seen);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(b[i], s);
            seen[i] = s;
        end
    endtask

    task automatic test_reset();
        logic [7:0] seen;
        logic ack;
        tick(3);
        n_cmp++; if (drv !== 1'b0)      begin n_bad++; $display("FAIL rst_drive got=%0b exp=0", drv); end
        n_cmp++; if (rxdata !== 8'h00)  begin n_bad++; $display("FAIL rst_rxdata got=%0h exp=00", rxdata); end
        n_cmp++; if ({busy, rxvalid, txreq} !== 3'b000)
            begin n_bad++; $display("FAIL rst_flags got=%0b exp=000", {busy, rxvalid, txreq}); end
        rst_n = 1'b1; tick(4);
        // Load non-reset values, then reset in the middle of a new address phase.
        bus_start(); send_byte({ADDR, 1'b0}, seen); bus_bit(1'b1, ack);
        send_byte(8'hAB, seen); bus_bit(1'b1, ack);
        bus_rstart();
        for (int i = 0; i < 4; i++) bus_bit(ADDR[6-i], ack);
        rst_n = 1'b0; #1;
        n_cmp++; if (rxdata !== 8'h00) begin n_bad++; $display("FAIL midrst_rxdata got=%0h exp=00", rxdata); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        n_cmp++; if (drv !== 1'b0)     begin n_bad++; $display("FAIL midrst_drive got=%0b exp=0", drv); end
        tick(2); m_sda = 1'b1; tick(2); scl = 1'b1; tick(4);
        rst_n = 1'b1; tick(4);
        bus_start(); send_byte({ADDR, 1'b0}, seen); bus_bit(1'b1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL restart_ack got=%0b exp=0", ack); end
        bus_stop(); tick(4);
    endtask

    task automatic test_write();
        logic [7:0] seen;
        logic ack;
        int rxv0;
        rxv0 = rxv_cnt;
        bus_start(); send_byte({ADDR, 1'b0}, seen); bus_bit(1'b1, ack);
        n_cmp++; if (ack !== 1'b0)  begin n_bad++; $display("FAIL wr_addr_ack got=%0b exp=0", ack); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy got=%0b exp=1", busy); end
        send_byte(8'hAB, seen); bus_bit(1'b1, ack);
        n_cmp++; if (ack !== 1'b0)     begin n_bad++; $display("FAIL wr_data_ack got=%0b exp=0", ack); end
        n_cmp++; if (rxdata !== 8'hAB) begin n_bad++; $display("FAIL wr_rxdata got=%0h exp=ab", rxdata); end
        n_cmp++; if (rxv_cnt - rxv0 !== 1) begin n_bad++; $display("FAIL wr_rxvalid got=%0d exp=1", rxv_cnt - rxv0); end
        bus_stop(); tick(4);
        n_cmp++; if ({busy, drv} !== 2'b00) begin n_bad++; $display("FAIL wr_stop got=%0b exp=00", {busy, drv}); end
    endtask

    task automatic test_addr_mismatch();
        logic [7:0] seen;
        logic ack;
        int rxv0, drv0;
        rxv0 = rxv_cnt; drv0 = drv_cnt;
        bus_start(); send_byte({7'h22, 1'b0}, seen); bus_bit(1'b1, ack);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL mm_ack got=%0b exp=1", ack); end
        send_byte(8'h35, seen); bus_bit(1'b1, ack);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mm_busy got=%0b exp=0", busy); end
        bus_stop(); tick(4);
        n_cmp++; if (drv_cnt - drv0 !== 0) begin n_bad++; $display("FAIL mm_drive got=%0d exp=0", drv_cnt - drv0); end
        n_cmp++; if (rxv_cnt - rxv0 !== 0) begin n_bad++; $display("FAIL mm_rxvalid got=%0d exp=0", rxv_cnt - rxv0); end
    endtask

    task automatic test_read();
        logic [7:0] seen;
        logic ack;
        int txr0, drv0;
        txr0 = txr_cnt;
        bus_start(); send_byte({ADDR, 1'b1}, seen);
        tx_data = 8'h35; bus_bit(1'b1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack got=%0b exp=0", ack); end
        send_byte(8'hFF, seen);
        n_cmp++; if (seen !== 8'h35) begin n_bad++; $display("FAIL rd_byte0 got=%0h exp=35", seen); end
        tx_data = 8'hAB; bus_bit(1'b0, ack);
        send_byte(8'hFF, seen);
        n_cmp++; if (seen !== 8'hAB) begin n_bad++; $display("FAIL rd_byte1 got=%0h exp=ab", seen); end
        bus_bit(1'b1, ack);
        n_cmp++; if (txr_cnt - txr0 !== 2) begin n_bad++; $display("FAIL rd_txreq got=%0d exp=2", txr_cnt - txr0); end
        n_cmp++; if ({busy, drv} !== 2'b00) begin n_bad++; $display("FAIL rd_nack got=%0b exp=00", {busy, drv}); end
        drv0 = drv_cnt;
        send_byte(8'hFF, seen);
        n_cmp++; if (seen !== 8'hFF || drv_cnt != drv0)
            begin n_bad++; $display("FAIL rd_waitstop got=%0h exp=ff", seen); end
        bus_stop(); tick(4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen, b;
        logic ack;
        int rxv0;
        rxv0 = rxv_cnt;
        b = 8'($urandom);
        bus_start(); send_byte({ADDR, 1'b0}, seen); bus_bit(1'b1, ack);
        send_byte(8'hAB, seen); bus_bit(1'b1, ack);
        for (int i = 0; i < 3; i++) bus_bit(b[7-i], ack);
        bus_rstart(); send_byte({ADDR, 1'b1}, seen);
        tx_data = b; bus_bit(1'b1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rs_reack got=%0b exp=0", ack); end
        send_byte(8'hFF, seen);
        n_cmp++; if (seen !== b) begin n_bad++; $display("FAIL rs_read got=%0h exp=%0h", seen, b); end
        bus_bit(1'b1, ack); bus_stop(); tick(4);
        n_cmp++; if (rxv_cnt - rxv0 !== 1) begin n_bad++; $display("FAIL rs_rxvalid got=%0d exp=1", rxv_cnt - rxv0); end
        n_cmp++; if (rxdata !== 8'hAB)     begin n_bad++; $display("FAIL rs_rxdata got=%0h exp=ab", rxdata); end
    endtask

    task automatic test_stop_mid_write();
        logic [7:0] seen;
        logic ack;
        int rxv0;
        rxv0 = rxv_cnt;
        bus_start(); send_byte({ADDR, 1'b0}, seen); bus_bit(1'b1, ack);
        send_byte(8'hAB, seen); bus_bit(1'b1, ack);
        for (int i = 0; i < 5; i++) bus_bit(1'($urandom), ack);
        bus_stop(); tick(2);
        n_cmp++; if ({busy, drv} !== 2'b00) begin n_bad++; $display("FAIL sm_flags got=%0b exp=00", {busy, drv}); end
        n_cmp++; if (rxdata !== 8'hAB)      begin n_bad++; $display("FAIL sm_rxdata got=%0h exp=ab", rxdata); end
        n_cmp++; if (rxv_cnt - rxv0 !== 1)  begin n_bad++; $display("FAIL sm_rxvalid got=%0d exp=1", rxv_cnt - rxv0); end
    endtask

    // Random transactions against a transaction-level model of the target.
    task automatic test_random();
        logic [7:0] seen, b;
        logic [6:0] a;
        logic rw, ack, exp_ack;
        int n, rxv0, txr0;
        for (int t = 0; t < 12; t++) begin
            a  = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
            if (t < 2) a = ADDR ^ 7'(t + 1);
            rw = 1'($urandom);
            n  = $urandom_range(1, 3);
            exp_ack = (a == ADDR);
            rxv0 = rxv_cnt; txr0 = txr_cnt;
            bus_start(); send_byte({a, rw}, seen);
            b = 8'($urandom); tx_data = b;
            bus_bit(1'b1, ack);
            n_cmp++; if (ack !== !exp_ack) begin n_bad++; $display("FAIL rnd_addr a=%0h got=%0b exp=%0b", a, ack, !exp_ack); end
            if (exp_ack && !rw) begin
                for (int k = 0; k < n; k++) begin
                    b = 8'($urandom);
                    send_byte(b, seen); bus_bit(1'b1, ack);
                    n_cmp++; if (ack !== 1'b0 || rxdata !== b)
                        begin n_bad++; $display("FAIL rnd_wr got=%0h/%0b exp=%0h/0", rxdata, ack, b); end
                end
                n_cmp++; if (rxv_cnt - rxv0 !== n) begin n_bad++; $display("FAIL rnd_wr_cnt got=%0d exp=%0d", rxv_cnt - rxv0, n); end
            end else if (exp_ack) begin
                for (int k = 0; k < n; k++) begin
                    send_byte(8'hFF, seen);
                    n_cmp++; if (seen !== b) begin n_bad++; $display("FAIL rnd_rd got=%0h exp=%0h", seen, b); end
                    b = 8'($urandom); tx_data = b;
                    bus_bit((k == n - 1), ack);
                end
                n_cmp++; if (txr_cnt - txr0 !== n) begin n_bad++; $display("FAIL rnd_rd_cnt got=%0d exp=%0d", txr_cnt - txr0, n); end
            end
            bus_stop(); tick(4);
            n_cmp++; if ({busy, drv} !== 2'b00) begin n_bad++; $display("FAIL rnd_end got=%0b exp=00", {busy, drv}); end
        end
        n_cmp++; if (viol_cnt !== 0) begin n_bad++; $display("FAIL scl_high_drive got=%0d exp=0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_back_to_back();
        test_stop_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
